// File: rtl/ym_fp_pkg.sv
// ym_fp_pkg
// Shared constants and the floating-point to linear conversion used by the
// YM-style serial receiver. The serial word is {exp[2:0], mant[9:0]}.
// No ports (package).
package ym_fp_pkg;

   localparam int FP_W      = 13;
   localparam int MANT_W    = 10;
   localparam int EXP_W     = 3;
   localparam int MANT_BIAS = 512;

   typedef struct packed {
      logic signed [31:0] sample;
      logic               zero_exp;
   } fp_lin_t;

   // Mantissa is offset-binary around MANT_BIAS. Exponent 1..7 scales by
   // 2^(exp-1). Exponent 0 is not a legal code from the chip, so it decodes
   // to silence and is reported through zero_exp.
   function automatic fp_lin_t fp_to_lin(input logic [FP_W-1:0] word, input int out_w);
      fp_lin_t                   res;
      logic [EXP_W-1:0]          e;
      logic signed [MANT_W:0]    m;
      logic signed [31:0]        m_ext;
      e     = word[FP_W-1 -: EXP_W];
      m     = $signed({1'b0, word[MANT_W-1:0]}) - (MANT_W+1)'(MANT_BIAS);
      m_ext = 32'(m);
      res.zero_exp = (e == '0);
      if (e == '0)
         res.sample = '0;
      else
         res.sample = m_ext <<< (e - 3'd1);
      // Keep the result within out_w bits as a signed quantity.
      for (int b = 0; b < 32; b++)
         if (b >= out_w) res.sample[b] = res.sample[out_w-1];
      return res;
   endfunction

endpackage

// File: rtl/ym_fp_serial_mixer_if.sv
// ym_fp_serial_mixer_if
// Bus bundle for the serial floating-point mixer.
//   Inputs to the mixer : BIT_EN, SH1, SH2, SDI[NUM_IN], IN_EN[NUM_IN], ERR_CLR
//   Outputs of the mixer: SMP_L/SMP_R (packed per lane), VALID_L/VALID_R,
//                         MIX_L/MIX_R, MIX_VALID_L/MIX_VALID_R, ERR[NUM_IN]
// master = stimulus side, slave = mixer side.
interface ym_fp_serial_mixer_if #(
   parameter int NUM_IN = 2,
   parameter int OUT_W  = 16
);
   logic                      BIT_EN;
   logic                      SH1;
   logic                      SH2;
   logic [NUM_IN-1:0]         SDI;
   logic [NUM_IN-1:0]         IN_EN;
   logic                      ERR_CLR;
   logic [NUM_IN*OUT_W-1:0]   SMP_L;
   logic [NUM_IN*OUT_W-1:0]   SMP_R;
   logic                      VALID_L;
   logic                      VALID_R;
   logic [OUT_W-1:0]          MIX_L;
   logic [OUT_W-1:0]          MIX_R;
   logic                      MIX_VALID_L;
   logic                      MIX_VALID_R;
   logic [NUM_IN-1:0]         ERR;

   modport master (
      output BIT_EN, SH1, SH2, SDI, IN_EN, ERR_CLR,
      input  SMP_L, SMP_R, VALID_L, VALID_R, MIX_L, MIX_R,
             MIX_VALID_L, MIX_VALID_R, ERR
   );

   modport slave (
      input  BIT_EN, SH1, SH2, SDI, IN_EN, ERR_CLR,
      output SMP_L, SMP_R, VALID_L, VALID_R, MIX_L, MIX_R,
             MIX_VALID_L, MIX_VALID_R, ERR
   );
endinterface

// File: rtl/ym_fp_lane.sv
// ym_fp_lane
// One serial input lane: 13-bit LSB-first shift register, left/right slot
// latch with float-to-linear decode, and a sticky zero-exponent flag.
//   clk, rst        : clock, synchronous active-high reset
//   bit_en, sdi     : shift strobe and serial bit
//   fall_l, fall_r  : slot latch strobes (SH1/SH2 falling edges)
//   err_clr         : clears err
//   smp_l, smp_r    : decoded samples per slot
//   err             : sticky zero-exponent flag
module ym_fp_lane
   import ym_fp_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bit_en,
   input  logic                    sdi,
   input  logic                    fall_l,
   input  logic                    fall_r,
   input  logic                    err_clr,
   output logic signed [OUT_W-1:0] smp_l,
   output logic signed [OUT_W-1:0] smp_r,
   output logic                    err
);

   logic [FP_W-1:0] sr;
   fp_lin_t         dec;

   // Decode uses the register value before this cycle's shift, so a bit
   // arriving together with the slot edge belongs to the next word.
   always_comb dec = fp_to_lin(sr, OUT_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         sr    <= '0;
         smp_l <= '0;
         smp_r <= '0;
         err   <= 1'b0;
      end else begin
         if (bit_en) sr <= {sdi, sr[FP_W-1:1]};
         if (fall_l) smp_l <= OUT_W'(dec.sample);
         if (fall_r) smp_r <= OUT_W'(dec.sample);
         // A new bad word overrides a simultaneous clear.
         err <= ((fall_l | fall_r) & dec.zero_exp) | (err & ~err_clr);
      end
   end

endmodule

// File: rtl/ym_fp_serial_mixer.sv
// ym_fp_serial_mixer
// N-lane receiver for YM2151/YM3012-style serial floating-point audio with
// per-side saturating mix of the enabled lanes.
//   CLK, RES : clock, synchronous active-high reset
//   bus      : ym_fp_serial_mixer_if.slave (serial inputs, framing, enables,
//              per-lane samples, mixes, valids, error flags)
// Latency: SH falling edge -> VALID 1 CLK -> MIX_VALID 1 CLK later.
module ym_fp_serial_mixer
   import ym_fp_pkg::*;
#(
   parameter int NUM_IN = 2,
   parameter int OUT_W  = 16
) (
   input  logic                   CLK,
   input  logic                   RES,
   ym_fp_serial_mixer_if.slave    bus
);

   localparam int SUM_W = OUT_W + $clog2(NUM_IN) + 1;
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > SAT_MAX)
         return {1'b0, {(OUT_W-1){1'b1}}};
      else if (v < SAT_MIN)
         return {1'b1, {(OUT_W-1){1'b0}}};
      else
         return v[OUT_W-1:0];
   endfunction

   logic                      sh1_q, sh2_q;
   logic                      fall_l, fall_r;
   logic [NUM_IN*OUT_W-1:0]   smp_l_bus, smp_r_bus;
   logic [NUM_IN-1:0]         err_vec;
   logic                      vld_l_p1, vld_r_p1;
   logic                      vld_l_p2, vld_r_p2;
   logic signed [OUT_W-1:0]   mix_l_p2, mix_r_p2;
   logic signed [SUM_W-1:0]   sum_l, sum_r;

   assign fall_l = sh1_q & ~bus.SH1;
   assign fall_r = sh2_q & ~bus.SH2;

   // Stage p0 -> p1: lanes latch and decode on the slot edge
   for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
      ym_fp_lane #(.OUT_W(OUT_W)) u_lane (
         .clk     (CLK),
         .rst     (RES),
         .bit_en  (bus.BIT_EN),
         .sdi     (bus.SDI[i]),
         .fall_l  (fall_l),
         .fall_r  (fall_r),
         .err_clr (bus.ERR_CLR),
         .smp_l   (smp_l_bus[i*OUT_W +: OUT_W]),
         .smp_r   (smp_r_bus[i*OUT_W +: OUT_W]),
         .err     (err_vec[i])
      );
   end

   always_comb begin
      sum_l = '0;
      sum_r = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bus.IN_EN[i]) begin
            sum_l = sum_l + SUM_W'($signed(smp_l_bus[i*OUT_W +: OUT_W]));
            sum_r = sum_r + SUM_W'($signed(smp_r_bus[i*OUT_W +: OUT_W]));
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         sh1_q    <= 1'b0;
         sh2_q    <= 1'b0;
         vld_l_p1 <= 1'b0;
         vld_r_p1 <= 1'b0;
         vld_l_p2 <= 1'b0;
         vld_r_p2 <= 1'b0;
         mix_l_p2 <= '0;
         mix_r_p2 <= '0;
      end else begin
         sh1_q    <= bus.SH1;
         sh2_q    <= bus.SH2;
         vld_l_p1 <= fall_l;
         vld_r_p1 <= fall_r;
         // Stage p1 -> p2: mix the freshly latched samples
         vld_l_p2 <= vld_l_p1;
         vld_r_p2 <= vld_r_p1;
         if (vld_l_p1) mix_l_p2 <= sat(sum_l);
         if (vld_r_p1) mix_r_p2 <= sat(sum_r);
      end
   end

   assign bus.SMP_L       = smp_l_bus;
   assign bus.SMP_R       = smp_r_bus;
   assign bus.VALID_L     = vld_l_p1;
   assign bus.VALID_R     = vld_r_p1;
   assign bus.MIX_L       = mix_l_p2;
   assign bus.MIX_R       = mix_r_p2;
   assign bus.MIX_VALID_L = vld_l_p2;
   assign bus.MIX_VALID_R = vld_r_p2;
   assign bus.ERR         = err_vec;

endmodule
